// File: rtl/me_pkg.sv
// me_pkg: shared types for the memory stage
package me_pkg;
  localparam int ME_DW = 32;
  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_RSV} mem_size_e;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} me_state_e;
  typedef struct packed {
    logic               rf_we;
    logic               load;
    logic               we;
    mem_size_e          size;
    logic               uns;
    logic [1:0]         off;
    logic [ME_DW/8-1:0] be;
    logic [ME_DW-1:0]   wdata;
  } me_op_t;
endpackage

// File: rtl/memory_stage_lsu_align.sv
// lsu_align: store lane placement, misalign detection and load extraction
module lsu_align
  import me_pkg::*;
(
  input  mem_size_e          st_size_i,
  input  logic [1:0]         st_off_i,
  input  logic [ME_DW-1:0]   st_data_i,
  output logic [ME_DW/8-1:0] be_o,
  output logic [ME_DW-1:0]   wdata_o,
  output logic               misalign_o,
  input  mem_size_e          ld_size_i,
  input  logic [1:0]         ld_off_i,
  input  logic               ld_unsigned_i,
  input  logic [ME_DW-1:0]   rdata_i,
  output logic [ME_DW-1:0]   ld_data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  // replicate store data across lanes, pick the addressed lane of load data and extend it
  always_comb begin
    be_o = st_size_i == MEM_B ? 4'b0001 << st_off_i : st_size_i == MEM_H ? 4'b0011 << st_off_i : st_size_i == MEM_W ? 4'hF : 4'h0;
    wdata_o = st_size_i == MEM_B ? {4{st_data_i[7:0]}} : st_size_i == MEM_H ? {2{st_data_i[15:0]}} : st_data_i;
    misalign_o = st_size_i == MEM_RSV || (st_size_i == MEM_H && st_off_i[0]) || (st_size_i == MEM_W && st_off_i != 2'd0);
    b = rdata_i[{ld_off_i, 3'b000} +: 8];
    h = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    ld_data_o = ld_size_i == MEM_B ? {{24{b[7] & ~ld_unsigned_i}}, b}
              : ld_size_i == MEM_H ? {{16{h[15] & ~ld_unsigned_i}}, h}
              : rdata_i;
  end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: ME pipeline stage issuing data-memory accesses and feeding WB
module memory_stage
  import me_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic                 rf_we_i,
  input  logic [RF_ADDR_W-1:0] rf_waddr_i,
  input  logic                 mem_re_i,
  input  logic                 mem_we_i,
  input  logic [1:0]           mem_size_i,
  input  logic                 mem_unsigned_i,
  input  logic [DATA_W-1:0]    alu_result_i,
  input  logic [DATA_W-1:0]    store_data_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [DATA_W/8-1:0]  dmem_be_o,
  output logic [ADDR_W-1:0]    dmem_addr_o,
  output logic [DATA_W-1:0]    dmem_wdata_o,
  input  logic                 dmem_gnt_i,
  input  logic                 dmem_rvalid_i,
  input  logic [DATA_W-1:0]    dmem_rdata_i,
  output logic                 rf_we_o,
  output logic [RF_ADDR_W-1:0] rf_waddr_o,
  output logic                 mem2rf_o,
  output logic [DATA_W-1:0]    mem_rdata_o,
  output logic [DATA_W-1:0]    alu_result_o,
  output logic                 misalign_o
);
  if (DATA_W != ME_DW) begin : g_dw_check
    $error("memory_stage: only DATA_W=32 is supported");
  end
  if (ADDR_W < 3 || ADDR_W > DATA_W) begin : g_aw_check
    $error("memory_stage: ADDR_W must be between 3 and DATA_W");
  end
  me_state_e            state_q, state_d;
  me_op_t               op_q, op_d;
  logic [DATA_W-1:0]    alu_q, ld_data, wdata;
  logic [DATA_W/8-1:0]  be;
  logic [RF_ADDR_W-1:0] waddr_q;
  logic                 accept, is_mem, mis, st_done, ld_done;
  lsu_align u_align (
    .st_size_i    (mem_size_e'(mem_size_i)),
    .st_off_i     (alu_result_i[1:0]),
    .st_data_i    (store_data_i),
    .be_o         (be),
    .wdata_o      (wdata),
    .misalign_o   (mis),
    .ld_size_i    (op_q.size),
    .ld_off_i     (op_q.off),
    .ld_unsigned_i(op_q.uns),
    .rdata_i      (dmem_rdata_i),
    .ld_data_o    (ld_data)
  );
  assign ex_ready_o   = state_q == IDLE;
  assign dmem_req_o   = state_q == REQ;
  assign dmem_we_o    = op_q.we;
  assign dmem_be_o    = op_q.be;
  assign dmem_wdata_o = op_q.wdata;
  assign dmem_addr_o  = {alu_q[ADDR_W-1:2], 2'b00};
  // handshake decode, op capture and next state; rvalid only matters in WAIT_R
  always_comb begin
    accept  = ex_valid_i && state_q == IDLE;
    is_mem  = mem_re_i || mem_we_i;
    st_done = state_q == REQ && dmem_gnt_i && !op_q.load;
    ld_done = state_q == WAIT_R && dmem_rvalid_i;
    op_d    = '{rf_we: rf_we_i, load: mem_re_i, we: mem_we_i && !mem_re_i, size: mem_size_e'(mem_size_i),
                uns: mem_unsigned_i, off: alu_result_i[1:0], be: be, wdata: wdata};
    state_d = state_q == IDLE ? (accept && is_mem && !mis ? REQ : IDLE)
            : state_q == REQ  ? (dmem_gnt_i ? (op_q.load ? WAIT_R : IDLE) : REQ)
            : (dmem_rvalid_i ? IDLE : WAIT_R);
  end
  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // op register and WB outputs; rf_we_o and misalign_o are single-cycle pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q         <= '0;
      alu_q        <= '0;
      waddr_q      <= '0;
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= '0;
      mem2rf_o     <= 1'b0;
      mem_rdata_o  <= '0;
      alu_result_o <= '0;
      misalign_o   <= 1'b0;
    end else begin
      rf_we_o    <= 1'b0;
      misalign_o <= accept && is_mem && mis;
      if (accept) begin
        op_q    <= op_d;
        alu_q   <= alu_result_i;
        waddr_q <= rf_waddr_i;
      end
      if (accept && !is_mem) begin
        rf_we_o      <= rf_we_i;
        rf_waddr_o   <= rf_waddr_i;
        mem2rf_o     <= 1'b0;
        alu_result_o <= alu_result_i;
      end
      if (st_done) begin
        rf_waddr_o   <= waddr_q;
        mem2rf_o     <= 1'b0;
        alu_result_o <= alu_q;
      end
      if (ld_done) begin
        rf_we_o      <= op_q.rf_we;
        rf_waddr_o   <= waddr_q;
        mem2rf_o     <= 1'b1;
        mem_rdata_o  <= ld_data;
        alu_result_o <= alu_q;
      end
    end
  end
endmodule
